// File: rtl/time_display.sv
// Eight-digit multiplexed HH.MM.SS seven-segment driver with frame-coherent time latching.
// Define TIME_DISPLAY_ALARM_BLINK_EN to blank the display on alternate half-periods while alarm is high.
module time_display #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLINK_TICKS = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] disp_time,
    input  logic        alarm,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SCAN_W = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGIT_TICKS - 1);

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;
    logic [2:0]        idx;
    logic [16:0]       frame;
    logic              phase;

    logic [5:0]        field;
    logic [3:0]        digit;
    logic [7:0]        an_next;
    logic [6:0]        seg_next;
    logic              dp_next;

    assign scan_tc = (scan_cnt == SCAN_LAST);

    // frame only reloads as the index wraps, so a displayed frame is never torn
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            frame    <= 17'd0;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
            if (idx == 3'd7) begin
                frame <= disp_time;
            end
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

`ifdef TIME_DISPLAY_ALARM_BLINK_EN
    localparam int BLINK_W = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic [BLINK_W-1:0] blink_cnt;

    // idle alarm parks the blinker so every alarm opens with a full on half-period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (!alarm) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end
`else
    localparam int unused_blink_ticks = BLINK_TICKS;
    logic unused_alarm;
    assign unused_alarm = alarm;
    assign phase        = 1'b1;
`endif

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        logic [5:0] t6;
        t6 = {2'b00, tens_of(v)};
        return 4'(v - t6 * 6'd10);
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // index pairs: 0/1 seconds, 2/3 minutes, 4/5 hours; odd index is the tens digit
    always_comb begin
        field = frame[5:0];
        case (idx[2:1])
            2'd1:    field = frame[11:6];
            2'd2:    field = {1'b0, frame[16:12]};
            default: field = frame[5:0];
        endcase
        digit = idx[0] ? tens_of(field) : units_of(field);
    end

    always_comb begin
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (idx <= 3'd5) begin
            an_next  = ~(8'd1 << idx);
            seg_next = seg_of(digit);
            dp_next  = !((idx == 3'd2) || (idx == 3'd4));
        end
        if (!phase) begin
            an_next = 8'hFF;
            dp_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Bench for time_display: directed scenarios plus random time/alarm traffic against an edge-count reference model.
module tb_time_display;

    localparam int D     = 4;
    localparam int B     = 16;
    localparam int FRAME = 8 * D;
`ifdef TIME_DISPLAY_ALARM_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [16:0] disp_time;
    logic        alarm;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    time_display #(.DIGIT_TICKS(D), .BLINK_TICKS(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_time (disp_time),
        .alarm     (alarm),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: m_* describe the display after the latest edge,
    // e_* hold the values from before it, which the registered outputs show.
    int unsigned m_k, m_run, e_k, e_run;
    logic [16:0] m_frame, e_frame;
    bit          e_live;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k <= 0; m_run <= 0; m_frame <= '0;
            e_k <= 0; e_run <= 0; e_frame <= '0; e_live <= 1'b0;
        end else begin
            e_live  <= 1'b1;
            e_k     <= m_k;
            e_frame <= m_frame;
            e_run   <= m_run;
            m_k     <= m_k + 1;
            if ((m_k + 1) % FRAME == 0) m_frame <= disp_time;
            m_run   <= alarm ? m_run + 1 : 0;
        end
    end

    function automatic void model_out(input bit live, input int unsigned k,
                                      input logic [16:0] fr, input int unsigned run,
                                      output logic [7:0] a, output logic [6:0] s,
                                      output logic d);
        int unsigned ix, val;
        a = 8'hFF; s = 7'h7F; d = 1'b1;
        if (!live) return;
        ix = (k / D) % 8;
        if (ix < 6) begin
            case (ix / 2)
                0:       val = 32'(fr[5:0]);
                1:       val = 32'(fr[11:6]);
                default: val = 32'(fr[16:12]);
            endcase
            val = (ix % 2 == 0) ? val % 10 : val / 10;
            a = ~(8'd1 << ix);
            s = seg_ref[val];
            d = !(ix == 2 || ix == 4);
        end
        if (BLINK_EN && ((run / B) % 2 == 1)) begin
            a = 8'hFF;
            d = 1'b1;
        end
    endfunction

    logic [7:0] xa;
    logic [6:0] xs;
    logic       xd;

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic test_reset();
        reset = 1'b0; alarm = 1'b0; disp_time = hms(12, 34, 56);
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold an=%h exp ff seg=%h exp 7f dp=%b exp 1", an, seg, dp);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_release an=%h exp fe seg=%h exp 40 dp=%b exp 1", an, seg, dp);
        end
    endtask

    task automatic test_first_frames();
        int seen_tens_hr = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            model_out(e_live, e_k, e_frame, e_run, xa, xs, xd);
            checks++;
            if (an !== xa || dp !== xd || (xa != 8'hFF && seg !== xs)) begin
                failures++;
                $display("FAIL first_frames t=%0t an=%h exp %h seg=%h exp %h dp=%b exp %b",
                         $time, an, xa, seg, xs, dp, xd);
            end
            if (an == 8'hDF && seg == 7'h79) seen_tens_hr++;
        end
        // hour tens digit of 12:34:56 appears for one digit slot per frame once latched
        checks++;
        if (seen_tens_hr != D) begin
            failures++;
            $display("FAIL hr_tens_cycles got %0d exp %0d", seen_tens_hr, D);
        end
    endtask

    task automatic test_mid_frame_change();
        int guard = 0;
        while (((m_k / D) % 8) != 3 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 2 * FRAME) begin
            failures++;
            $display("FAIL mid_frame_wait got timeout exp index 3");
        end
        disp_time = hms(23, 59, 59);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            model_out(e_live, e_k, e_frame, e_run, xa, xs, xd);
            checks++;
            if (an !== xa || dp !== xd || (xa != 8'hFF && seg !== xs)) begin
                failures++;
                $display("FAIL mid_frame t=%0t an=%h exp %h seg=%h exp %h dp=%b exp %b",
                         $time, an, xa, seg, xs, dp, xd);
            end
        end
    endtask

    task automatic test_dp();
        int dp_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (dp === 1'b0 && an !== 8'hFB && an !== 8'hEF) begin
                failures++;
                $display("FAIL dp_position an=%h dp=%b exp dp 1", an, dp);
            end
            if (dp === 1'b0) dp_low++;
        end
        checks++;
        if (dp_low != 2 * D) begin
            failures++;
            $display("FAIL dp_count got %0d exp %0d", dp_low, 2 * D);
        end
    endtask

    task automatic test_alarm();
        alarm = 1'b1;
        for (int i = 0; i < 64 + 40; i++) begin
            if (i == 64) alarm = 1'b0;
            @(negedge clk);
            model_out(e_live, e_k, e_frame, e_run, xa, xs, xd);
            checks++;
            if (an !== xa || dp !== xd || (xa != 8'hFF && seg !== xs)) begin
                failures++;
                $display("FAIL alarm t=%0t an=%h exp %h seg=%h exp %h dp=%b exp %b",
                         $time, an, xa, seg, xs, dp, xd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            model_out(e_live, e_k, e_frame, e_run, xa, xs, xd);
            checks++;
            if (an !== xa || dp !== xd || (xa != 8'hFF && seg !== xs)) begin
                failures++;
                $display("FAIL random t=%0t an=%h exp %h seg=%h exp %h dp=%b exp %b",
                         $time, an, xa, seg, xs, dp, xd);
            end
            if ($urandom_range(0, 19) == 0)
                disp_time = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                             6'($urandom_range(0, 63))};
            if ($urandom_range(0, 39) == 0) alarm = ~alarm;
        end
        alarm = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL async_reset an=%h exp ff seg=%h exp 7f dp=%b exp 1", an, seg, dp);
        end
        @(negedge clk);
        reset = 1'b1;
        disp_time = hms(9, 8, 7);
        @(negedge clk);
        checks++;
        if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
            failures++;
            $display("FAIL restart an=%h exp fe seg=%h exp 40 dp=%b exp 1", an, seg, dp);
        end
        for (int i = 0; i < FRAME + 2 * D; i++) begin
            @(negedge clk);
            model_out(e_live, e_k, e_frame, e_run, xa, xs, xd);
            checks++;
            if (an !== xa || dp !== xd || (xa != 8'hFF && seg !== xs)) begin
                failures++;
                $display("FAIL restart_frames t=%0t an=%h exp %h seg=%h exp %h dp=%b exp %b",
                         $time, an, xa, seg, xs, dp, xd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_mid_frame_change();
        test_dp();
        test_alarm();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 100000, meaning clk cycles each digit is driven (must be >= 2).
REQ-002 SHALL have parameter BLINK_TICKS, default 50000000, meaning clk cycles per alarm blink half-period (must be >= 2).
REQ-003 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port disp_time  input  17  time to show: [16:12] hours, [11:6] minutes, [5:0] seconds, unsigned binary.
REQ-006 SHALL have port alarm  input  1  alarm trigger, level, synchronous to clk.
REQ-007 SHALL have port an  output  8  digit anodes, active-low, an[0] = rightmost digit.
REQ-008 SHALL have port seg  output  7  segments, active-low, seg[0]=CA ... seg[6]=CG.
REQ-009 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-010 SHALL hold a scan counter counting 0..DIGIT_TICKS-1, wrapping to 0; terminal count = value DIGIT_TICKS-1.
REQ-011 SHALL hold a 3-bit digit index incrementing by 1 on each scan terminal count, wrapping 7->0.
REQ-012 SHALL latch disp_time into an internal frame register on the edge where the index wraps 7->0, so one full frame never mixes two times.
REQ-013 SHALL convert each latched field (0..63) to tens/units BCD; values above 59 (min/sec) or 23 (hours) display as-is, with no clamping.
REQ-014 SHALL map index 0..5 to sec units, sec tens, min units, min tens, hr units, hr tens; indices 6 and 7 SHALL drive their anode high (blank).
REQ-015 SHALL drive exactly one anode low for indices 0..5, matching the index (an = ~(1<<index)).
REQ-016 SHALL encode digits 0-9 in standard 7-segment form, e.g. 0 -> seg=7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000.
REQ-017 SHALL drive dp low only on indices 2 and 4 (HH.MM.SS separators), high otherwise.
REQ-018 SHALL register an/seg/dp, so outputs reflect a new index exactly one clk cycle after the index changes.
REQ-019 SHALL hold a blink counter 0..BLINK_TICKS-1 and a blink phase bit (1 = on) that toggles at the blink terminal count, but only while alarm=1.
REQ-020 SHALL hold the blink counter at 0 and the phase at 1 while alarm=0, so each alarm starts with a full on half-period.
REQ-021 SHALL force an=8'hFF and dp=1 during the off phase, leaving seg don't-care, while scan and latching continue unaffected.
REQ-022 SHALL make a simultaneous alarm rise and scan terminal count take effect independently in the same cycle.
REQ-023 SHALL apply a change of disp_time mid-frame only at the next 7->0 wrap.

Reset
REQ-024 SHALL, while reset=0, force an=8'hFF, seg=7'h7F, dp=1, scan counter=0, index=0, frame register=0, blink counter=0, and phase=1.
REQ-025 SHALL, on the first edge after reset release, drive index 0 (an=8'hFE, seg=7'b1000000), showing the frame register value 0.
REQ-026 SHALL, on an asserted reset mid-frame, return all outputs to reset values immediately, without waiting for a clock edge.

Configuration
REQ-027 SHALL, when macro TIME_DISPLAY_ALARM_BLINK_EN is defined, implement blink per REQ-019..REQ-021.
REQ-028 SHALL, when TIME_DISPLAY_ALARM_BLINK_EN is undefined, omit the blink counter and phase, ignore alarm, and keep the display always on.

Verification (DIGIT_TICKS=4, BLINK_TICKS=16)
REQ-029 SHALL cover: reset release with disp_time=12:34:56 -> first frame shows 00:00:00; from the second frame, digits 5..0 show seg for 1,2,3,4,5,6 with an stepping FE,FD,FB,F7,EF,DF then FF,FF, 4 cycles each.
REQ-030 SHALL cover: disp_time changes 12:34:56 -> 23:59:59 at index 3 -> the rest of the frame still shows 12:34:56; the next frame shows 2,3,5,9,5,9.
REQ-031 SHALL cover: dp check over one frame -> dp=0 only while an=FB and an=EF.
REQ-032 SHALL cover: with the macro defined, alarm=1 for 64 cycles -> an alternates between normal scan (16 cycles) and FF (16 cycles); after alarm=0, scan resumes on the next cycle with phase on.
REQ-033 SHALL cover: with the macro undefined, the same alarm stimulus -> an never forced to FF outside indices 6 and 7.
REQ-034 SHALL cover: reset asserted asynchronously mid-digit -> an=FF and seg=7F before the next clk edge; restart per REQ-025.
